// File: rtl/memristor_array_responder.sv
// rtl/memristor_array_responder.sv - 32x32 memristor crossbar model with in-array OR/AND/XOR/INV compute
//
// Purpose:
//   Holds a 32-row x 32-bit non-volatile array. It accepts either a compute
//   request or a write request. A compute request is exactly one operation
//   strobe with control[0]=0; it spends SENSE_CYCLES in SENSE, then one RESULT
//   cycle. A write request is control[0]=1 with no strobe; it spends
//   PROGRAM_CYCLES in PROGRAM. Conflicting strobes are rejected with a
//   one-cycle error pulse. The array is not cleared by reset.
//
// Optional feature (macro MEMRISTOR_WRITEBACK_EN):
//   When defined and the latched control[1]=1, the RESULT cycle also writes
//   the result into row control[12:8]. When undefined, there is no
//   write-back logic and those control bits are ignored.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   synchronous active-high reset
//   bit_data_sel_1 in  32   operand-A row (bits [4:0]); also the write row
//   bit_data_sel_2 in  32   operand-B row (bits [4:0])
//   control        in  32   [0] write req, [1] write-back en, [12:8] write-back row
//   word           in  32   data to program
//   read_or_gate   in   1   OR strobe (plain read when both selects are equal)
//   and_gate       in   1   AND strobe
//   xor_gate       in   1   XOR strobe
//   inv_gate       in   1   INV strobe (operand B ignored)
//   data           out 32   compute result, held until the next RESULT
//   data_valid     out  1   one-cycle pulse in the RESULT cycle
//   busy           out  1   high in SENSE, RESULT and PROGRAM
//   write_done     out  1   one-cycle pulse in the final PROGRAM cycle
//   error          out  1   one-cycle pulse after a rejected request

module memristor_array_responder #(
    parameter int SENSE_CYCLES   = 2,
    parameter int PROGRAM_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bit_data_sel_1,
    input  logic [31:0] bit_data_sel_2,
    input  logic [31:0] control,
    input  logic [31:0] word,
    input  logic        read_or_gate,
    input  logic        and_gate,
    input  logic        xor_gate,
    input  logic        inv_gate,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        busy,
    output logic        write_done,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SENSE   = 2'd1,
        S_RESULT  = 2'd2,
        S_PROGRAM = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2,
        OP_INV = 2'd3
    } op_t;

    localparam logic [3:0] SENSE_CNT   = SENSE_CYCLES[3:0];
    localparam logic [3:0] PROGRAM_CNT = PROGRAM_CYCLES[3:0];

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [4:0]  row_a_q;      // operand-A row, doubles as the program row
    logic [4:0]  row_b_q;
    op_t         op_q;
    logic [31:0] word_q;
    logic [31:0] data_q;
    logic        data_valid_q;
    logic        busy_q;
    logic        write_done_q;
    logic        error_q;

    logic [31:0] mem_q [32];

`ifdef MEMRISTOR_WRITEBACK_EN
    logic        wb_en_q;
    logic [4:0]  wb_row_q;
    logic        wb_we_d;
`endif

    // Upper select bits and unused control bits are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{bit_data_sel_1[31:5], bit_data_sel_2[31:5], control[31:1]};

    // Request decode
    logic [2:0] strobe_cnt_d;
    logic       any_strobe_d;
    logic       compute_req_d;
    logic       write_req_d;
    logic       reject_d;
    op_t        op_d;

    assign strobe_cnt_d  = {2'b00, read_or_gate} + {2'b00, and_gate}
                         + {2'b00, xor_gate}     + {2'b00, inv_gate};
    assign any_strobe_d  = (strobe_cnt_d != 3'd0);
    assign compute_req_d = (strobe_cnt_d == 3'd1) && !control[0];
    assign write_req_d   = control[0] && !any_strobe_d;
    assign reject_d      = (strobe_cnt_d > 3'd1) || (any_strobe_d && control[0]);

    always_comb begin
        op_d = OP_OR;
        if (and_gate)      op_d = OP_AND;
        else if (xor_gate) op_d = OP_XOR;
        else if (inv_gate) op_d = OP_INV;
    end

    // Operands are read from the array only at SENSE exit.
    logic [31:0] opa_d;
    logic [31:0] opb_d;
    logic [31:0] result_d;

    assign opa_d = mem_q[row_a_q];
    assign opb_d = mem_q[row_b_q];

    always_comb begin
        result_d = 32'd0;
        case (op_q)
            OP_OR:   result_d = opa_d | opb_d;
            OP_AND:  result_d = opa_d & opb_d;
            OP_XOR:  result_d = opa_d ^ opb_d;
            OP_INV:  result_d = ~opa_d;
            default: result_d = 32'd0;
        endcase
    end

    // The row is committed at the end of the final PROGRAM cycle; a reset
    // arriving earlier returns to IDLE before this point is reached.
    logic prog_we_d;
    assign prog_we_d = (state_q == S_PROGRAM) && (cnt_q == 4'd1) && !rst;

`ifdef MEMRISTOR_WRITEBACK_EN
    assign wb_we_d = (state_q == S_RESULT) && wb_en_q && !rst;
`endif

    // Non-volatile array: no reset.
    always_ff @(posedge clk) begin
        if (prog_we_d) begin
            mem_q[row_a_q] <= word_q;
        end
`ifdef MEMRISTOR_WRITEBACK_EN
        if (wb_we_d) begin
            mem_q[wb_row_q] <= data_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            row_a_q      <= 5'd0;
            row_b_q      <= 5'd0;
            op_q         <= OP_OR;
            word_q       <= 32'd0;
            data_q       <= 32'd0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            write_done_q <= 1'b0;
            error_q      <= 1'b0;
`ifdef MEMRISTOR_WRITEBACK_EN
            wb_en_q      <= 1'b0;
            wb_row_q     <= 5'd0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            write_done_q <= 1'b0;
            error_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (compute_req_d) begin
                        row_a_q  <= bit_data_sel_1[4:0];
                        row_b_q  <= bit_data_sel_2[4:0];
                        op_q     <= op_d;
`ifdef MEMRISTOR_WRITEBACK_EN
                        wb_en_q  <= control[1];
                        wb_row_q <= control[12:8];
`endif
                        cnt_q    <= SENSE_CNT;
                        busy_q   <= 1'b1;
                        state_q  <= S_SENSE;
                    end else if (write_req_d) begin
                        row_a_q      <= bit_data_sel_1[4:0];
                        word_q       <= word;
                        cnt_q        <= PROGRAM_CNT;
                        busy_q       <= 1'b1;
                        // Pulse lands on the final PROGRAM cycle, which is
                        // the first one when PROGRAM_CYCLES is 1.
                        write_done_q <= (PROGRAM_CNT == 4'd1);
                        state_q      <= S_PROGRAM;
                    end else if (reject_d) begin
                        error_q <= 1'b1;
                    end
                end
                S_SENSE: begin
                    if (cnt_q == 4'd1) begin
                        data_q       <= result_d;
                        data_valid_q <= 1'b1;
                        state_q      <= S_RESULT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESULT: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_PROGRAM: begin
                    if (cnt_q == 4'd1) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q        <= cnt_q - 4'd1;
                        write_done_q <= (cnt_q == 4'd2);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign write_done = write_done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_memristor_array_responder.sv
// tb/tb_memristor_array_responder.sv - directed scoreboard bench for memristor_array_responder

module tb_memristor_array_responder;

    localparam int SENSE_CYCLES   = 2;
    localparam int PROGRAM_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bit_data_sel_1;
    logic [31:0] bit_data_sel_2;
    logic [31:0] control;
    logic [31:0] word;
    logic        read_or_gate;
    logic        and_gate;
    logic        xor_gate;
    logic        inv_gate;
    logic [31:0] data;
    logic        data_valid;
    logic        busy;
    logic        write_done;
    logic        error;

    always #5 clk = ~clk;

    memristor_array_responder #(
        .SENSE_CYCLES  (SENSE_CYCLES),
        .PROGRAM_CYCLES(PROGRAM_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bit_data_sel_1(bit_data_sel_1),
        .bit_data_sel_2(bit_data_sel_2),
        .control       (control),
        .word          (word),
        .read_or_gate  (read_or_gate),
        .and_gate      (and_gate),
        .xor_gate      (xor_gate),
        .inv_gate      (inv_gate),
        .data          (data),
        .data_valid    (data_valid),
        .busy          (busy),
        .write_done    (write_done),
        .error         (error)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bit_data_sel_1 = 32'd0;
        bit_data_sel_2 = 32'd0;
        control        = 32'd0;
        word           = 32'd0;
        read_or_gate   = 1'b0;
        and_gate       = 1'b0;
        xor_gate       = 1'b0;
        inv_gate       = 1'b0;
    endtask

    task automatic drive_op(input int op, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] ctrl);
        idle_inputs();
        bit_data_sel_1 = s1;
        bit_data_sel_2 = s2;
        control        = ctrl;
        read_or_gate   = (op == 0);
        and_gate       = (op == 1);
        xor_gate       = (op == 2);
        inv_gate       = (op == 3);
    endtask

    task automatic do_write(input logic [4:0] row, input logic [31:0] w, input string tag);
        int lat;
        @(negedge clk);
        idle_inputs();
        control        = 32'd1;
        bit_data_sel_1 = {27'd0, row};
        word           = w;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
            if (write_done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_wr_latency"}, lat, PROGRAM_CYCLES);
        model[row] = w;
    endtask

    task automatic do_compute(input int op, input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] ctrl, input logic [31:0] exp, input string tag);
        int lat;
        logic [31:0] got;
        @(negedge clk);
        drive_op(op, s1, s2, ctrl);
        exp_q.push_back(exp);
        @(posedge clk);
        lat = 0;
        got = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) idle_inputs();
            if (data_valid) begin
                lat = k;
                got = data;
                break;
            end
        end
        chk({tag, "_latency"}, lat, SENSE_CYCLES + 1);
        chk({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() != 0) chk({tag, "_data"}, got, exp_q.pop_front());
    endtask

    initial begin
        int pulses;
        int errs;
        logic [31:0] r7_before;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", data, 32'd0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_write_done", write_done, 0);
        chk("rst_error", error, 0);
        rst = 1'b0;

        do_write(5'd7, 32'h7777_0007, "w7");
        do_write(5'd1, 32'hFF00_FF00, "w1");
        do_write(5'd2, 32'h0F0F_0F0F, "w2");
        do_write(5'd3, 32'hF0F0_1234, "w3");

        do_compute(0, 32'd3, 32'd3, 32'd0, model[3], "read3");
        do_compute(1, 32'd1, 32'd2, 32'd0, model[1] & model[2], "and12");
        do_compute(0, 32'hABCD_EF01, 32'h1234_5682, 32'd0, model[1] | model[2], "or12_upper");
        do_compute(2, 32'd1, 32'd2, 32'd0, model[1] ^ model[2], "xor12");
        do_compute(3, 32'd1, 32'd3, 32'd0, ~model[1], "inv1");
        repeat (3) @(negedge clk);
        chk("data_hold", data, ~model[1]);

        // Rejected request: two strobes
        @(negedge clk);
        idle_inputs();
        and_gate = 1'b1;
        xor_gate = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        chk("rej2_error", error, 1);
        chk("rej2_busy", busy, 0);
        @(negedge clk);
        chk("rej2_error_clear", error, 0);

        // Rejected request: strobe with write request
        @(negedge clk);
        idle_inputs();
        inv_gate       = 1'b1;
        control        = 32'd1;
        bit_data_sel_1 = 32'd1;
        word           = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        chk("rejw_error", error, 1);
        chk("rejw_busy", busy, 0);
        do_compute(0, 32'd1, 32'd1, 32'd0, model[1], "row1_intact");
        do_compute(0, 32'd2, 32'd2, 32'd0, model[2], "row2_intact");

        // Request while busy is ignored
        @(negedge clk);
        drive_op(0, 32'd1, 32'd2, 32'd0);
        exp_q.push_back(model[1] | model[2]);
        @(posedge clk);
        pulses = 0;
        errs   = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) drive_op(1, 32'd3, 32'd3, 32'd0);
            if (k == 4) idle_inputs();
            if (error) errs++;
            if (data_valid) begin
                pulses++;
                chk("busy_ign_sb_depth", exp_q.size(), 1);
                if (exp_q.size() != 0) chk("busy_ign_data", data, exp_q.pop_front());
            end
        end
        chk("busy_ign_pulses", pulses, 1);
        chk("busy_ign_errors", errs, 0);
        chk("busy_ign_data_hold", data, model[1] | model[2]);

        // Write-back of XOR(1,2) into row 7
        r7_before = model[7];
        do_compute(2, 32'd1, 32'd2, 32'h0000_0702, model[1] ^ model[2], "xor_wb");
`ifdef MEMRISTOR_WRITEBACK_EN
        model[7] = model[1] ^ model[2];
`else
        model[7] = r7_before;
`endif
        do_compute(0, 32'd7, 32'd7, 32'd0, model[7], "row7_check");

        // Reset during PROGRAM cycle 2
        do_write(5'd5, 32'h1111_1111, "w5");
        @(negedge clk);
        idle_inputs();
        control        = 32'd1;
        bit_data_sel_1 = 32'd5;
        word           = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        chk("prog_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("prst_data", data, 32'd0);
        chk("prst_data_valid", data_valid, 0);
        chk("prst_busy", busy, 0);
        chk("prst_write_done", write_done, 0);
        chk("prst_error", error, 0);
        rst = 1'b0;
        do_compute(0, 32'd5, 32'd5, 32'd0, model[5], "row5_kept");

        // Reset during SENSE: no data_valid
        @(negedge clk);
        drive_op(1, 32'd1, 32'd2, 32'd0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (data_valid) pulses++;
        end
        chk("srst_no_valid", pulses, 0);
        chk("srst_busy", busy, 0);
        do_compute(2, 32'd3, 32'd1, 32'd0, model[3] ^ model[1], "post_srst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
